// File: rtl/fetch_if.sv
// Signal bundle between the fetch unit, the instruction memory and the core.
// fetch_unit connects through the master modport; the environment uses slave.
interface fetch_if #(
  parameter int NPC_SEL_W = 2
);
  logic [NPC_SEL_W-1:0] npc_sel;
  logic                 advance;
  logic [31:0]          reg_target;
  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic                 imem_rvalid;
  logic [31:0]          imem_rdata;
  logic [31:0]          instr;
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 instr_valid;
  logic [31:0]          pc;
  logic [31:0]          pc_plus4;
  logic                 fault;
  logic [31:0]          retired;

  modport master (
    input  npc_sel, advance, reg_target, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr, opcode, funct, instr_valid,
           pc, pc_plus4, fault, retired
  );

  modport slave (
    output npc_sel, advance, reg_target, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instr, opcode, funct, instr_valid,
           pc, pc_plus4, fault, retired
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: requests one word at pc, holds it for decode until the
// core retires it, then computes the next pc from npc_sel.
//   state | meaning
//   IDLE  | one cycle after reset
//   FETCH | imem_req high at pc, waiting for imem_rvalid
//   HOLD  | instr valid for decode, waiting for advance
//   FAULT | misaligned next pc seen; left only through reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          NPC_SEL_W = 2
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  state_t               state, state_nxt;
  logic [31:0]          pc_q, pc_nxt;
  logic [31:0]          instr_q, instr_nxt;
  logic [31:0]          retired_q, retired_nxt;
  logic [31:0]          pc_plus4;
  logic [31:0]          br_off;
  logic [31:0]          target;
  logic [NPC_SEL_W-1:0] sel;

  assign sel      = bus.npc_sel;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    target = pc_plus4;
    case (sel[1:0])
      2'b00:   target = pc_plus4;
      2'b01:   target = pc_plus4 + br_off;
      2'b10:   target = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      default: target = bus.reg_target;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      instr_q   <= instr_nxt;
      retired_q <= retired_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    instr_nxt   = instr_q;
    retired_nxt = retired_q;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (bus.imem_rvalid) begin
          instr_nxt = bus.imem_rdata;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.advance) begin
          retired_nxt = retired_q + 32'd1;
          pc_nxt      = target;
          // A misaligned target is still recorded in pc so it can be inspected.
          state_nxt   = (target[1:0] != 2'b00) ? FAULT : FETCH;
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.instr_valid = (state == HOLD);
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fault       = (state == FAULT);
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of the
// fetch / hold / advance sequence and the next-pc rules.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;

  fetch_if #(.NPC_SEL_W(2)) bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .NPC_SEL_W(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ins,
                                            input logic [1:0] sel, input logic [31:0] rt);
    longint off;
    off = ins[15] ? longint'(ins[15:0]) - 65536 : longint'(ins[15:0]);
    case (sel)
      2'd0:    return 32'(longint'(p) + 4);
      2'd1:    return 32'(longint'(p) + 4 + off * 4);
      2'd2:    return ((p + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
      default: return rt;
    endcase
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    bus.advance = 1'b0;
    bus.imem_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    m_pc = RESET_PC;
    m_instr = 32'd0;
    m_retired = 32'd0;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc", bus.pc, m_pc);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    tick();
    chk("idle_to_fetch_req", 32'(bus.imem_req), 32'd1);
    chk("idle_to_fetch_addr", bus.imem_addr, m_pc);
  endtask

  task automatic do_fetch(input logic [31:0] d, input int waits);
    for (int w = 0; w < waits; w++) begin
      bus.advance = ($urandom_range(0, 2) == 0);
      chk("wait_req", 32'(bus.imem_req), 32'd1);
      chk("wait_addr", bus.imem_addr, m_pc);
      tick();
      chk("wait_retired", bus.retired, m_retired);
    end
    bus.advance = 1'b0;
    chk("fetch_req", 32'(bus.imem_req), 32'd1);
    chk("fetch_addr", bus.imem_addr, m_pc);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = d;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = $urandom;
    m_instr = d;
    chk("hold_valid", 32'(bus.instr_valid), 32'd1);
    chk("hold_req", 32'(bus.imem_req), 32'd0);
    chk("hold_instr", bus.instr, m_instr);
    chk("hold_opcode", 32'(bus.opcode), m_instr >> 26);
    chk("hold_funct", 32'(bus.funct), m_instr & 32'h3F);
    chk("hold_pc", bus.pc, m_pc);
    chk("hold_pc4", bus.pc_plus4, m_pc + 32'd4);
    if ($urandom_range(0, 1) == 1) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = ~d;
      tick();
      bus.imem_rvalid = 1'b0;
      chk("stray_rvalid_instr", bus.instr, m_instr);
      chk("stray_rvalid_valid", 32'(bus.instr_valid), 32'd1);
      chk("stray_rvalid_pc", bus.pc, m_pc);
    end
  endtask

  task automatic do_advance(input logic [1:0] sel, input logic [31:0] rt, output bit faulted);
    logic [31:0] npc;
    npc = model_npc(m_pc, m_instr, sel, rt);
    bus.npc_sel = sel;
    bus.reg_target = rt;
    bus.advance = 1'b1;
    tick();
    bus.advance = 1'b0;
    bus.npc_sel = 2'($urandom);
    bus.reg_target = $urandom;
    m_retired = m_retired + 32'd1;
    m_pc = npc;
    faulted = (npc % 4) != 0;
    chk("adv_retired", bus.retired, m_retired);
    chk("adv_pc", bus.pc, m_pc);
    chk("adv_valid", 32'(bus.instr_valid), 32'd0);
    if (faulted) begin
      chk("fault_flag", 32'(bus.fault), 32'd1);
      chk("fault_req", 32'(bus.imem_req), 32'd0);
      for (int k = 0; k < 3; k++) begin
        bus.advance = 1'($urandom);
        bus.imem_rvalid = 1'($urandom);
        tick();
        chk("fault_sticky", 32'(bus.fault), 32'd1);
        chk("fault_noreq", 32'(bus.imem_req), 32'd0);
        chk("fault_pc", bus.pc, m_pc);
        chk("fault_retired", bus.retired, m_retired);
      end
      bus.advance = 1'b0;
      bus.imem_rvalid = 1'b0;
    end else begin
      chk("adv_fault", 32'(bus.fault), 32'd0);
      chk("adv_req", 32'(bus.imem_req), 32'd1);
      chk("adv_addr", bus.imem_addr, m_pc);
    end
  endtask

  initial begin
    bit f;
    bus.npc_sel = 2'd0;
    bus.advance = 1'b0;
    bus.reg_target = 32'd0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'd0;

    // Directed cases from the reset address
    do_reset();
    do_fetch(32'h1000_FFFF, 3);
    chk("d_opcode_branch", 32'(bus.opcode), 32'h04);
    do_advance(2'b01, 32'd0, f);
    chk("d_branch_self", bus.imem_addr, 32'h0000_3000);
    chk("d_branch_retired", bus.retired, 32'd1);

    do_fetch(32'h3C01_1234, 3);
    chk("d_opcode_lui", 32'(bus.opcode), 32'h0F);
    do_advance(2'b00, 32'd0, f);
    chk("d_seq_addr", bus.imem_addr, 32'h0000_3004);

    do_fetch(32'h0800_0C10, 1);
    do_advance(2'b10, 32'd0, f);
    chk("d_jump_addr", bus.imem_addr, 32'h0000_3040);

    do_fetch(32'h0000_0008, 0);
    do_advance(2'b11, 32'h0000_3006, f);
    chk("d_jr_fault", 32'(bus.fault), 32'd1);
    chk("d_jr_pc", bus.pc, 32'h0000_3006);

    // Reset in the middle of a fetch wait, with advance and rvalid also high
    do_reset();
    do_fetch(32'h2000_0001, 2);
    do_advance(2'b00, 32'd0, f);
    bus.advance = 1'b1;
    tick();
    reset = 1'b1;
    bus.imem_rvalid = 1'b1;
    tick();
    reset = 1'b0;
    bus.advance = 1'b0;
    bus.imem_rvalid = 1'b0;
    chk("midreset_pc", bus.pc, 32'h0000_3000);
    chk("midreset_retired", bus.retired, 32'd0);
    chk("midreset_req", 32'(bus.imem_req), 32'd0);
    chk("midreset_instr", bus.instr, 32'd0);
    m_pc = RESET_PC;
    m_instr = 32'd0;
    m_retired = 32'd0;
    tick();
    chk("midreset_fetch", bus.imem_addr, 32'h0000_3000);

    // Address wrap at the top of memory
    do_fetch(32'h0000_0000, 0);
    do_advance(2'b11, 32'hFFFF_FFFC, f);
    do_fetch(32'hABCD_0000, 1);
    do_advance(2'b00, 32'd0, f);
    chk("d_wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  sel;
      logic [31:0] rt;
      do_fetch($urandom, $urandom_range(0, 4));
      sel = 2'($urandom);
      rt = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) rt = rt | 32'($urandom_range(1, 3));
      do_advance(sel, rt, f);
      if (f) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the address of the first fetch after reset.
REQ-002 SHALL have parameter NPC_SEL_W, default 2, meaning the width of the next-PC select input.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port npc_sel, input, 2: 00 PC+4, 01 branch taken, 10 J-type jump, 11 register jump.
REQ-006 SHALL have port advance, input, 1, pulse from the core retiring the held instruction.
REQ-007 SHALL have port reg_target, input, 32, the jump-register target address.
REQ-008 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-009 SHALL have port imem_addr, output, 32, the read address, word aligned.
REQ-010 SHALL have port imem_rvalid, input, 1, read data valid.
REQ-011 SHALL have port imem_rdata, input, 32, read data.
REQ-012 SHALL have port instr, output, 32, the held instruction word.
REQ-013 SHALL have ports opcode (output, 6, instr[31:26]) and funct (output, 6, instr[5:0]).
REQ-014 SHALL have port instr_valid, output, 1, high while instr is valid for decode.
REQ-015 SHALL have ports pc (output, 32, address of the held instruction) and pc_plus4 (output, 32, pc+4, the jal return address).
REQ-016 SHALL have port fault, output, 1, sticky misaligned-target indication.
REQ-017 SHALL have port retired, output, 32, count of retired instructions.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD, FAULT.
REQ-019 IDLE SHALL last exactly one cycle after reset deasserts, then go to FETCH with imem_addr=pc.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL stay stable until the cycle imem_rvalid=1 (request-hold handshake, any number of wait cycles).
REQ-021 On imem_rvalid in FETCH, SHALL latch imem_rdata into instr, go to HOLD, and assert instr_valid from the next cycle (1-cycle fetch latency after rvalid).
REQ-022 imem_rvalid outside FETCH SHALL be ignored; instr SHALL not change.
REQ-023 In HOLD, instr_valid=1, imem_req=0; instr, pc and outputs SHALL be stable until advance.
REQ-024 On advance in HOLD, npc_sel, instr and reg_target SHALL be sampled in that same cycle, next PC computed, retired incremented, and the FSM SHALL go to FETCH; instr_valid=0 from the next cycle.
REQ-025 advance outside HOLD SHALL be ignored (no PC change, no count).
REQ-026 Next PC for 00 SHALL be pc+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
REQ-027 Next PC for 01 SHALL be pc+4+(sign-extended instr[15:0] << 2), mod 2^32.
REQ-028 Next PC for 10 SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-029 Next PC for 11 SHALL be reg_target.
REQ-030 If next PC[1:0] != 0, SHALL enter FAULT instead of FETCH: fault=1, pc=offending address, imem_req=0, instr_valid=0, retired still incremented.
REQ-031 FAULT SHALL be exited only by reset.
REQ-032 retired SHALL wrap from 0xFFFF_FFFF to 0.
REQ-033 pc_plus4 SHALL be combinational pc+4 at all times.

Reset
REQ-034 On reset=1 at a clock edge: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, retired=0, from any state including mid-FETCH.
REQ-035 Reset SHALL override a simultaneous advance or imem_rvalid.
REQ-036 Instruction memory shares reset; no stale response is expected after reset.

Verification
REQ-037 Reset, memory returns 0x3C01_1234 after 3 wait cycles -> imem_addr=0x3000 held 4 cycles; next cycle instr_valid=1, opcode=0x0F.
REQ-038 HOLD at pc=0x3000, instr=0x1000_FFFF, npc_sel=01, advance -> next fetch address 0x3000, retired=1.
REQ-039 pc=0x3004, instr=0x0800_0C10, npc_sel=10, advance -> next fetch address 0x0000_3040.
REQ-040 npc_sel=11, reg_target=0x0000_3006, advance -> fault=1, pc=0x3006, no further imem_req until reset.
REQ-041 Reset asserted during FETCH wait with advance=1 -> next cycle pc=0x3000, retired=0, state IDLE.
REQ-042 advance pulsed during FETCH and rvalid pulsed during HOLD -> no PC, count or instr change.
